// File: rtl/pe_array_row_scheduler.sv
// Row scheduler for one PE-array convolution pass: RAM-reset wait, flush, row-by-row loads, start, run.
// Optional watchdog enabled by defining PE_SCHED_TIMEOUT_EN (sets err and ends the pass on a stuck wait).
module pe_array_row_scheduler #(
  parameter int NUM_ROW = 7
`ifdef PE_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [7:0]         cmd_kernel_size,
  input  logic               cmd_skip_psum,
  output logic [7:0]         kernel_size,
  output logic [NUM_ROW-1:0] load_fltr,
  output logic [NUM_ROW-1:0] load_ifmap,
  output logic [NUM_ROW-1:0] load_psum,
  output logic [NUM_ROW-1:0] flush_tag,
  output logic [NUM_ROW-1:0] flush_kernel,
  output logic [NUM_ROW-1:0] start,
  input  logic [NUM_ROW-1:0] ram_rst_busy,
  input  logic [NUM_ROW-1:0] tag_busy,
  input  logic [NUM_ROW-1:0] kernel_busy,
  input  logic [NUM_ROW-1:0] ram_load_busy,
  input  logic [NUM_ROW-1:0] full,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int RW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
  localparam logic [7:0] NUM_ROW_K = 8'(NUM_ROW);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_WAIT, S_FLUSH, S_FLUSH_WAIT, S_LD_FLTR,
    S_LD_IFMAP, S_LD_PSUM, S_START, S_RUN, S_DONE
  } state_e;

  state_e             state_q, state_d, ld_next;
  logic [1:0]         phase_q, phase_d;
  logic [RW-1:0]      row_q, row_d, last_row_q, last_row_d, last_row_new;
  logic [NUM_ROW-1:0] act_mask_q, act_mask_d, mask_new, row_oh, ld_pulse;
  logic [7:0]         kernel_size_q, kernel_size_d;
  logic               skip_psum_q, skip_psum_d;

`ifdef PE_SCHED_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYC - 1);
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d, in_wait, wd_expire;

  assign in_wait = (state_q == S_RST_WAIT) || (state_q == S_FLUSH_WAIT) || (state_q == S_RUN) ||
                   (((state_q == S_LD_FLTR) || (state_q == S_LD_IFMAP) || (state_q == S_LD_PSUM)) &&
                    (phase_q == 2'd2));
  assign wd_expire = in_wait && (wd_q == WD_LIMIT);
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Active rows = clamp(K, 1, NUM_ROW), kept as the last row index plus a contiguous mask.
  always_comb begin
    if (cmd_kernel_size == 8'd0)           last_row_new = '0;
    else if (cmd_kernel_size > NUM_ROW_K)  last_row_new = RW'(NUM_ROW - 1);
    else                                   last_row_new = RW'(cmd_kernel_size - 8'd1);
    for (int i = 0; i < NUM_ROW; i++) mask_new[i] = (RW'(i) <= last_row_new);
  end

  // NOTE: every flop updates non-blocking so all of them sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      row_q         <= '0;
      last_row_q    <= '0;
      act_mask_q    <= '0;
      kernel_size_q <= '0;
      skip_psum_q   <= 1'b0;
`ifdef PE_SCHED_TIMEOUT_EN
      wd_q          <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      row_q         <= row_d;
      last_row_q    <= last_row_d;
      act_mask_q    <= act_mask_d;
      kernel_size_q <= kernel_size_d;
      skip_psum_q   <= skip_psum_d;
`ifdef PE_SCHED_TIMEOUT_EN
      wd_q          <= wd_d;
      err_q         <= err_d;
`endif
    end
  end

  // NOTE: defaults assigned first so no branch leaves a signal unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    row_d         = row_q;
    last_row_d    = last_row_q;
    act_mask_d    = act_mask_q;
    kernel_size_d = kernel_size_q;
    skip_psum_d   = skip_psum_q;
`ifdef PE_SCHED_TIMEOUT_EN
    err_d         = err_q;
`endif
    ld_next = S_START;
    if (state_q == S_LD_FLTR)                        ld_next = S_LD_IFMAP;
    else if (state_q == S_LD_IFMAP && !skip_psum_q)  ld_next = S_LD_PSUM;

    unique case (state_q)
      S_IDLE: if (cmd_valid) begin
        state_d       = S_RST_WAIT;
        phase_d       = '0;
        row_d         = '0;
        last_row_d    = last_row_new;
        act_mask_d    = mask_new;
        kernel_size_d = cmd_kernel_size;
        skip_psum_d   = cmd_skip_psum;
`ifdef PE_SCHED_TIMEOUT_EN
        err_d         = 1'b0;
`endif
      end
      S_RST_WAIT: if ((ram_rst_busy & act_mask_q) == '0) state_d = S_FLUSH;
      S_FLUSH: begin
        state_d = S_FLUSH_WAIT;
        phase_d = '0;
      end
      // Busy flags lag the flush pulse by a cycle, so the first wait cycle ignores them.
      S_FLUSH_WAIT:
        if (phase_q == 2'd0) phase_d = 2'd1;
        else if (((tag_busy | kernel_busy) & act_mask_q) == '0) begin
          state_d = S_LD_FLTR;
          phase_d = '0;
        end
      S_LD_FLTR, S_LD_IFMAP, S_LD_PSUM:
        if (phase_q != 2'd2) phase_d = phase_q + 2'd1;
        else if (!ram_load_busy[row_q]) begin
          phase_d = '0;
          if (row_q == last_row_q) begin
            row_d   = '0;
            state_d = ld_next;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      S_START: state_d = S_RUN;
      S_RUN:   if ((full & act_mask_q) == act_mask_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef PE_SCHED_TIMEOUT_EN
    if (wd_expire) begin
      state_d = S_DONE;
      phase_d = '0;
      row_d   = '0;
      err_d   = 1'b1;
    end
    wd_d = ((state_d != state_q) || (phase_d != phase_q) || (row_d != row_q)) ? '0 : wd_q + 16'd1;
`endif
  end

  // Outputs decode registered state only; nothing passes combinationally from inputs.
  always_comb begin
    row_oh       = NUM_ROW'(1) << row_q;
    ld_pulse     = (phase_q == 2'd0) ? row_oh : '0;
    cmd_ready    = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    kernel_size  = kernel_size_q;
    load_fltr    = (state_q == S_LD_FLTR)  ? ld_pulse : '0;
    load_ifmap   = (state_q == S_LD_IFMAP) ? ld_pulse : '0;
    load_psum    = (state_q == S_LD_PSUM)  ? ld_pulse : '0;
    flush_tag    = (state_q == S_FLUSH)    ? act_mask_q : '0;
    flush_kernel = (state_q == S_FLUSH)    ? act_mask_q : '0;
    start        = (state_q == S_START)    ? act_mask_q : '0;
  end

endmodule

// File: tb/tb_pe_array_row_scheduler.sv
// Directed bench for pe_array_row_scheduler: behavioural busy/full responders, pulse recorder,
// hand-timed expected pulse schedules. Timeout scenario runs only with PE_SCHED_TIMEOUT_EN.
module tb_pe_array_row_scheduler;
  localparam int NR = 7;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_ready, cmd_skip_psum, busy, done, err;
  logic [7:0]    cmd_kernel_size, kernel_size;
  logic [NR-1:0] load_fltr, load_ifmap, load_psum, flush_tag, flush_kernel, start;
  logic [NR-1:0] ram_rst_busy, tag_busy, kernel_busy, ram_load_busy, full;

  pe_array_row_scheduler #(
    .NUM_ROW(NR)
`ifdef PE_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYC(64)
`endif
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kernel_size(cmd_kernel_size), .cmd_skip_psum(cmd_skip_psum), .kernel_size(kernel_size),
    .load_fltr(load_fltr), .load_ifmap(load_ifmap), .load_psum(load_psum),
    .flush_tag(flush_tag), .flush_kernel(flush_kernel), .start(start),
    .ram_rst_busy(ram_rst_busy), .tag_busy(tag_busy), .kernel_busy(kernel_busy),
    .ram_load_busy(ram_load_busy), .full(full), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int t; int kind; logic [NR-1:0] vec; } ev_t;
  ev_t evq[$];
  ev_t expq[$];

  // Pulse recorder: kinds 0 fltr, 1 ifmap, 2 psum, 3 flush_tag, 4 flush_kernel, 5 start, 6 done.
  always @(negedge clk) begin
    if (load_fltr    != '0) evq.push_back('{cyc, 0, load_fltr});
    if (load_ifmap   != '0) evq.push_back('{cyc, 1, load_ifmap});
    if (load_psum    != '0) evq.push_back('{cyc, 2, load_psum});
    if (flush_tag    != '0) evq.push_back('{cyc, 3, flush_tag});
    if (flush_kernel != '0) evq.push_back('{cyc, 4, flush_kernel});
    if (start        != '0) evq.push_back('{cyc, 5, start});
    if (done === 1'b1)      evq.push_back('{cyc, 6, NR'(1)});
  end

  // Array model: busy for 2 cycles after each load/flush pulse, full 10 cycles after start.
  // junk drives inactive rows so masking is exercised.
  logic [NR-1:0] junk = '0;
  logic [NR-1:0] ld_vec = '0, fl_vec = '0, run_vec = '0;
  int ld_cnt = 0, fl_cnt = 0, run_cnt = 0;
  bit full_en = 1'b1;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      ld_cnt = 0; fl_cnt = 0; run_cnt = 0;
      ram_load_busy = junk; tag_busy = junk; kernel_busy = junk; full = junk;
    end else begin
      if (ld_cnt > 0) begin ram_load_busy = ld_vec | junk; ld_cnt--; end
      else ram_load_busy = junk;
      if ((load_fltr | load_ifmap | load_psum) != '0) begin
        ld_cnt = 2; ld_vec = load_fltr | load_ifmap | load_psum;
      end
      if (fl_cnt > 0) begin tag_busy = fl_vec | junk; kernel_busy = fl_vec | junk; fl_cnt--; end
      else begin tag_busy = junk; kernel_busy = junk; end
      if (flush_tag != '0) begin fl_cnt = 2; fl_vec = flush_tag; end
      if (run_cnt > 0) begin
        run_cnt--;
        if (run_cnt == 0) full = run_vec | junk;
      end
      if (start != '0 && full_en) begin run_cnt = 10; run_vec = start; end
      if (done === 1'b1) full = junk;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int t, input int kind, input logic [NR-1:0] v);
    return {t[15:0], kind[3:0], 5'b0, v};
  endfunction

  task automatic issue(input int k, input bit skip, input bit hold);
    @(negedge clk);
    evq.delete();
    cmd_kernel_size = 8'(k);
    cmd_skip_psum   = skip;
    cmd_valid       = 1'b1;
    check("cmd_ready_idle", 32'(cmd_ready), 1);
    acc = cyc;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    check("kernel_size_latched", 32'(kernel_size), k);
    check("busy_in_pass", 32'(busy), 1);
    check("cmd_ready_low", 32'(cmd_ready), 0);
    check("err_clear_on_accept", 32'(err), 0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    bit rdy_seen = 1'b0;
    logic got;
    do begin
      @(negedge clk);
      n++;
      if (cmd_ready !== 1'b0) rdy_seen = 1'b1;
      got = done;
    end while (got !== 1'b1 && n < budget);
    #1;
    check("done_within_budget", 32'(got), 1);
    check("ready_low_while_busy", 32'(rdy_seen), 0);
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("idle_ready", 32'(cmd_ready), 1);
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
  endtask

  // Expected schedule: flush at fbase, then a load every 4 cycles (pulse, ignore, busy, busy-clear),
  // start after the last load row, done run_gap cycles after start.
  task automatic check_events(input int fbase, input int n, input bit skip,
                              input logic [NR-1:0] mask, input int run_gap);
    int t = fbase;
    int nph = skip ? 2 : 3;
    expq.delete();
    expq.push_back('{t, 3, mask});
    expq.push_back('{t, 4, mask});
    t += 4;
    for (int p = 0; p < nph; p++)
      for (int r = 0; r < n; r++) begin
        expq.push_back('{t, p, NR'(1) << r});
        t += 4;
      end
    expq.push_back('{t, 5, mask});
    expq.push_back('{t + run_gap, 6, NR'(1)});
    check("event_count", evq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < evq.size())
        check($sformatf("event%0d_time_kind_rows", i),
              pack(evq[i].t - acc, evq[i].kind, evq[i].vec),
              pack(expq[i].t, expq[i].kind, expq[i].vec));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_kernel_size = '0; cmd_skip_psum = 1'b0; ram_rst_busy = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_kernel_size", 32'(kernel_size), 0);
    check("rst_pulses", 32'({load_fltr, load_ifmap, load_psum, flush_tag}), 0);
    check("rst_pulses2", 32'({flush_kernel, start}), 0);
    rst = 1'b0;

    // K=3 full pass, inactive rows 3..6 held busy
    junk = 7'b1111000;
    issue(3, 1'b0, 1'b0);
    wait_done(200);
    check("k3_err", 32'(err), 0);
    check_events(2, 3, 1'b0, 7'b0000111, 11);
    idle_check();

    // K=0 -> row 0 only; RAM reset busy on an inactive row is ignored
    ram_rst_busy = 7'b0001000;
    issue(0, 1'b0, 1'b0);
    wait_done(200);
    check_events(2, 1, 1'b0, 7'b0000001, 11);
    idle_check();
    ram_rst_busy = '0;

    // K=9 -> all 7 rows, kernel_size stays 9
    junk = '0;
    issue(9, 1'b0, 1'b0);
    wait_done(300);
    check_events(2, 7, 1'b0, 7'b1111111, 11);
    idle_check();

    // skip_psum: start directly after last ifmap row
    issue(2, 1'b1, 1'b0);
    wait_done(200);
    check_events(2, 2, 1'b1, 7'b0000011, 11);
    idle_check();

    // RAM reset busy on row 1 for 20 cycles; cmd_valid held, second command taken after done
    ram_rst_busy = 7'b0000010;
    issue(2, 1'b0, 1'b1);
    cmd_kernel_size = 8'd5;
    repeat (19) @(negedge clk);
    check("kernel_size_stable", 32'(kernel_size), 2);
    check("no_flush_while_rst_busy", evq.size(), 0);
    ram_rst_busy = '0;
    wait_done(200);
    check_events(21, 2, 1'b0, 7'b0000011, 11);
    @(negedge clk);
    check("held_cmd_ready_after_done", 32'(cmd_ready), 1);
    check("held_busy_after_done", 32'(busy), 0);
    evq.delete();
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("second_cmd_kernel", 32'(kernel_size), 5);
    check("second_cmd_busy", 32'(busy), 1);
    wait_done(200);
    check_events(2, 5, 1'b0, 7'b0011111, 11);
    idle_check();

    // reset during LD_IFMAP row 1, then a fresh command
    issue(3, 1'b0, 1'b0);
    repeat (21) @(negedge clk);
    check("ifmap_row1_before_rst", 32'(load_ifmap), 32'h02);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pulses", 32'({load_fltr, load_ifmap, load_psum, flush_tag}), 0);
    check("midrst_pulses2", 32'({flush_kernel, start}), 0);
    check("midrst_state", 32'({cmd_ready, busy, done, err}), 32'h8);
    check("midrst_kernel_size", 32'(kernel_size), 0);
    rst = 1'b0;
    issue(1, 1'b0, 1'b0);
    wait_done(200);
    check_events(2, 1, 1'b0, 7'b0000001, 11);
    idle_check();

`ifdef PE_SCHED_TIMEOUT_EN
    // full never arrives: watchdog ends RUN after 64 cycles with err set
    full_en = 1'b0;
    issue(1, 1'b0, 1'b0);
    wait_done(300);
    check("timeout_err", 32'(err), 1);
    check_events(2, 1, 1'b0, 7'b0000001, 65);
    full_en = 1'b1;
    idle_check();
    check("err_sticky", 32'(err), 1);
    issue(1, 1'b0, 1'b0);
    wait_done(200);
    check_events(2, 1, 1'b0, 7'b0000001, 11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
